cpu_reset_seq: RTL and testbench

Core-side receiver of the clock/reset stimulus that drives cpu_main. It turns the raw active-low reset into a synchronised, staged release of the 5 pipeline stages. WB is released first and IF last, then a one-cycle PC reset-vector load is issued. After boot it also owns a halt/resume handshake: it stops fetch, waits for the pipeline to drain, then acknowledges.

---
 rtl/cpu_reset_seq_pkg.sv | 20 ++
 rtl/cpu_reset_seq_rst_sync.sv | 23 ++
 rtl/cpu_reset_seq.sv | 187 ++++++++++++++++++
 tb/tb_cpu_reset_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_reset_seq_pkg.sv
// cpu_reset_pkg: FSM encodings and pipeline stage indices
// shared by the core reset sequencer and its bench.
package cpu_reset_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_HALTED  = 3'd5
  } rst_state_t;

  localparam int IF  = 0;
  localparam int ID  = 1;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int WB  = 4;

endpackage

// File: rtl/cpu_reset_seq_rst_sync.sv
// rst_sync: reset synchroniser with asynchronous assert and
// synchronous deassert through a chain of STAGES flops.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_rst_s
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_s = r_chain[STAGES-1];

endmodule

// File: rtl/cpu_reset_seq.sv
// cpu_reset_seq: staged pipeline reset release (WB first, IF last),
// PC vector load and halt/drain handshake. Option: RST_WATCHDOG_EN.
module cpu_reset_seq
  import cpu_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGE_GAP     = 1,
  parameter int NUM_STAGES    = 5,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_req,
  input  logic                  pipe_idle,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  pc_load,
  output logic                  fetch_en,
  output logic                  cpu_running,
  output logic                  halt_ack,
  output logic                  drain_timeout,
  output logic [2:0]            state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

  rst_state_t            r_state;
  rst_state_t            w_state_nxt;
  logic [HW-1:0]         r_hold;
  logic [HW-1:0]         w_hold_nxt;
  logic [GW-1:0]         r_gap;
  logic [GW-1:0]         w_gap_nxt;
  logic [NUM_STAGES-1:0] r_stage;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic [NUM_STAGES-1:0] w_stage_shift;
  logic                  w_rst_s;

`ifdef RST_WATCHDOG_EN
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  logic [DW-1:0] r_wd;
  logic [DW-1:0] w_wd_nxt;
  logic          r_to;
  logic          w_to_nxt;
`endif

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .i_rst_n (rst),
    .o_rst_s (w_rst_s)
  );

  // a one shifts in from the WB end, so stages wake WB -> IF
  assign w_stage_shift = {1'b1, r_stage[NUM_STAGES-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold  <= '0;
      r_gap   <= '0;
      r_stage <= '0;
    end else begin
      r_hold  <= w_hold_nxt;
      r_gap   <= w_gap_nxt;
      r_stage <= w_stage_nxt;
    end
  end

`ifdef RST_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      r_wd <= w_wd_nxt;
      r_to <= w_to_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_gap_nxt   = r_gap;
    w_stage_nxt = r_stage;
    pc_load     = 1'b0;
    fetch_en    = 1'b0;
    cpu_running = 1'b0;
    halt_ack    = 1'b0;
`ifdef RST_WATCHDOG_EN
    w_wd_nxt    = '0;
    w_to_nxt    = r_to;
`endif
    unique case (r_state)
      ST_RESET: begin
        w_hold_nxt = '0;
        w_gap_nxt  = '0;
        // the first cycle with rst_s high is hold cycle 0
        if (w_rst_s) begin
          if (HOLD_CYCLES == 1) begin
            w_state_nxt = ST_RELEASE;
            w_stage_nxt = w_stage_shift;
          end else begin
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = HW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = ST_RELEASE;
          w_hold_nxt  = '0;
          w_stage_nxt = w_stage_shift;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      ST_RELEASE: begin
        pc_load = r_stage[IF];
        if (r_stage[IF]) begin
          w_state_nxt = ST_RUN;
        end else if (r_gap == GAP_LAST) begin
          w_gap_nxt   = '0;
          w_stage_nxt = w_stage_shift;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      ST_RUN: begin
        fetch_en    = 1'b1;
        cpu_running = 1'b1;
        if (halt_req) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_idle) begin
          w_state_nxt = ST_HALTED;
`ifdef RST_WATCHDOG_EN
        end else if (r_wd == DRAIN_LAST) begin
          w_state_nxt = ST_HALTED;
          w_to_nxt    = 1'b1;
`endif
        end else if (!halt_req) begin
          w_state_nxt = ST_RUN;
        end
`ifdef RST_WATCHDOG_EN
        if (w_state_nxt == ST_DRAIN) begin
          w_wd_nxt = r_wd + DW'(1);
        end
`endif
      end
      ST_HALTED: begin
        halt_ack = 1'b1;
        if (!halt_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  assign stage_rst_n = r_stage;
  assign state       = r_state;

`ifdef RST_WATCHDOG_EN
  assign drain_timeout = r_to;
`else
  assign drain_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_reset_seq.sv
// tb_cpu_reset_seq: scoreboard bench for the staged reset sequencer.
// Define RST_WATCHDOG_EN to also exercise the drain watchdog.
module tb_cpu_reset_seq;
  import cpu_reset_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt_req;
  logic       pipe_idle;
  logic [4:0] stage_rst_n;
  logic       pc_load;
  logic       fetch_en;
  logic       cpu_running;
  logic       halt_ack;
  logic       drain_timeout;
  logic [2:0] state;

  typedef struct {
    int         cyc;
    string      nm;
    logic [9:0] v;
    logic [2:0] st;
    bit         cs;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  cpu_reset_seq dut (
    .clk           (clk),
    .rst           (rst),
    .halt_req      (halt_req),
    .pipe_idle     (pipe_idle),
    .stage_rst_n   (stage_rst_n),
    .pc_load       (pc_load),
    .fetch_en      (fetch_en),
    .cpu_running   (cpu_running),
    .halt_ack      (halt_ack),
    .drain_timeout (drain_timeout),
    .state         (state)
  );

  task automatic push(input int c, input string nm,
                      input logic [4:0] s, input logic pc,
                      input logic run, input logic ack,
                      input logic to, input logic [2:0] st,
                      input bit cs);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.v   = {s, pc, run, run, ack, to};
    e.st  = st;
    e.cs  = cs;
    q.push_back(e);
  endtask

  task automatic p_zero(input int c, input string nm);
    push(c, nm, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, ST_RESET, 1'b1);
  endtask

  task automatic p_run(input int c, input string nm, input logic to);
    push(c, nm, 5'b11111, 1'b0, 1'b1, 1'b0, to, ST_RUN, 1'b1);
  endtask

  task automatic p_drain(input int c, input string nm);
    push(c, nm, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, ST_DRAIN, 1'b1);
  endtask

  task automatic p_halt(input int c, input string nm, input logic to);
    push(c, nm, 5'b11111, 1'b0, 1'b0, 1'b1, to, ST_HALTED, 1'b1);
  endtask

  // edge k after rst rises is sampled at negedge b+k
  task automatic boot_expect(input int b, input int kmax,
                             input string nm);
    logic [4:0] rel [0:4];
    rel[0] = 5'b10000;
    rel[1] = 5'b11000;
    rel[2] = 5'b11100;
    rel[3] = 5'b11110;
    rel[4] = 5'b11111;
    for (int k = 1; k <= kmax; k++) begin
      if (k < 18) begin
        push(b + k, nm, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0,
             ST_RESET, (k <= 2));
      end else if (k < 23) begin
        push(b + k, nm, rel[k-18], (k == 22), 1'b0, 1'b0, 1'b0,
             ST_RELEASE, 1'b1);
      end else begin
        p_run(b + k, nm, 1'b0);
      end
    end
  endtask

  task automatic wait_cyc(input int t);
    do begin
      @(negedge clk);
      #1;
    end while (cyc < t);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      got = {stage_rst_n, pc_load, fetch_en, cpu_running,
             halt_ack, drain_timeout};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_total = n_total + 1;
        if (e.cyc != cyc) begin
          $display("FAIL %s cyc=%0d not sampled (now %0d)",
                   e.nm, e.cyc, cyc);
        end else if (got !== e.v || (e.cs && state !== e.st)) begin
          $display("FAIL %s cyc=%0d got srn/pc/fe/run/ack/to=%b st=%0d want %b st=%0d",
                   e.nm, cyc, got, state, e.v, e.st);
        end else begin
          n_pass = n_pass + 1;
        end
      end
    end
  end

  initial begin : stim
    int c;
    int b;
    int guard;
    rst       = 1'b0;
    halt_req  = 1'b0;
    pipe_idle = 1'b0;

    p_zero(5, "rst_hold");
    p_zero(12, "rst_hold");
    p_zero(19, "rst_hold");
    boot_expect(20, 23, "bootA");
    #200;
    rst = 1'b1;

    wait_cyc(45);
    c = cyc;
    halt_req = 1'b1;
    for (int j = 1; j <= 5; j++) p_drain(c + j, "drain");
    for (int j = 6; j <= 8; j++) p_halt(c + j, "halted", 1'b0);
    p_run(c + 9, "resume", 1'b0);
    p_run(c + 10, "resume", 1'b0);
    wait_cyc(c + 5);
    pipe_idle = 1'b1;
    wait_cyc(c + 8);
    halt_req  = 1'b0;
    pipe_idle = 1'b0;
    wait_cyc(c + 10);

    c = cyc;
    halt_req = 1'b1;
    p_drain(c + 1, "idle_win_d");
    p_halt(c + 2, "idle_win_h", 1'b0);
    p_run(c + 3, "idle_win_r", 1'b0);
    p_run(c + 4, "idle_ignored", 1'b0);
    wait_cyc(c + 1);
    halt_req  = 1'b0;
    pipe_idle = 1'b1;
    wait_cyc(c + 4);
    pipe_idle = 1'b0;

    c = cyc;
    halt_req = 1'b1;
    p_drain(c + 1, "abandon_d");
    p_drain(c + 2, "abandon_d");
    p_run(c + 3, "abandon_r", 1'b0);
    p_run(c + 4, "abandon_r", 1'b0);
    wait_cyc(c + 2);
    halt_req = 1'b0;
    wait_cyc(c + 4);

    c = cyc;
    rst = 1'b0;
    p_zero(c + 1, "rst_async");
    wait_cyc(c + 1);
    b = cyc;
    rst = 1'b1;
    boot_expect(b, 19, "bootD1");
    p_zero(b + 20, "glitch");
    boot_expect(b + 20, 23, "bootD2");
    wait_cyc(b + 19);
    @(posedge clk);
    #1 rst = 1'b0;
    #3 rst = 1'b1;
    wait_cyc(b + 44);

    c = cyc;
    rst = 1'b0;
    p_zero(c + 1, "rst_async2");
    wait_cyc(c + 1);
    b = cyc;
    rst = 1'b1;
    boot_expect(b, 23, "bootE");
    p_drain(b + 24, "early_drain");
    p_drain(b + 25, "early_drain");
    p_run(b + 26, "early_resume", 1'b0);
    wait_cyc(b + 4);
    halt_req = 1'b1;
    wait_cyc(b + 25);
    halt_req = 1'b0;
    wait_cyc(b + 27);

`ifdef RST_WATCHDOG_EN
    c = cyc;
    halt_req  = 1'b1;
    pipe_idle = 1'b0;
    p_drain(c + 1, "wd_drain");
    p_drain(c + 64, "wd_drain_last");
    p_halt(c + 65, "wd_halted", 1'b1);
    p_run(c + 67, "wd_sticky", 1'b1);
    p_zero(c + 68, "wd_clear");
    wait_cyc(c + 66);
    halt_req = 1'b0;
    wait_cyc(c + 67);
    rst = 1'b0;
    wait_cyc(c + 69);
    rst = 1'b1;
`endif

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard = guard + 1;
    end
    #1;
    if (q.size() > 0) begin
      n_total = n_total + 1;
      $display("FAIL drain_queue left=%0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
